// File: rtl/hc595_scan_ctrl.sv
// hc595_scan_ctrl: multiplexed scan of up to eight 7-segment digits through
// two cascaded 74HC595 shift registers.
// For each digit the controller builds a 16-bit word {sel, seg}, shifts it
// MSB first on ds/shcp, pulses stcp to latch it, and then dwells before
// moving on to the next digit.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   en         scan enable; the current digit always runs to the end of its dwell
//   disp_data  hex nibbles, digit k = disp_data[4k+3:4k]
//   dp         decimal point per digit (1 = lit)
//   blank      blank per digit (1 = all segments off)
//   ds         HC595 serial data (registered)
//   shcp       HC595 shift clock (registered)
//   stcp       HC595 storage clock (registered)
//   oe_n       HC595 output enable, active low (registered)
//   busy       high whenever the FSM is not idle
//   frame_done one-cycle pulse as the last digit's dwell completes
module hc595_scan_ctrl #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned N_DIGITS    = 6,
  parameter int unsigned SCAN_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] disp_data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  output logic                  ds,
  output logic                  shcp,
  output logic                  stcp,
  output logic                  oe_n,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DwellW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DivW-1:0]   DivMax    = DivW'(CLK_DIV - 1);
  localparam logic [DwellW-1:0] DwellMax  = DwellW'(SCAN_CYCLES - 1);
  localparam logic [2:0]        LastDigit = 3'(N_DIGITS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StLatch, StDwell} state_e;

  state_e              state_q, state_d;
  logic [2:0]          digit_q, digit_d;
  logic [15:0]         word_q, word_d;
  logic [3:0]          bit_q, bit_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic                shcp_q, shcp_d;
  logic                stcp_q, stcp_d;
  logic                oe_n_q, oe_n_d;
  logic                div_done, dwell_done, last_digit;
  logic [7:0]          sel, seg;
  logic [3:0]          nibble;

  // Active-low segments, bit order {dp,g,f,e,d,c,b,a}.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign div_done   = (div_q == DivMax);
  assign dwell_done = (dwell_q == DwellMax);
  assign last_digit = (digit_q == LastDigit);

  // Word for the current digit; only sampled into word_q while in StLoad.
  always_comb begin
    nibble = disp_data[{digit_q, 2'b00} +: 4];
    sel    = 8'b1 << digit_q;
    seg    = hex_to_seg(nibble);
    if (dp[digit_q]) begin
      seg[7] = 1'b0;
    end
    if (blank[digit_q]) begin
      seg = 8'hFF;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (div_done && shcp_q && bit_q == 4'd15) state_d = StLatch;
      StLatch: if (div_done) state_d = StDwell;
      StDwell: if (dwell_done) state_d = en ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state; pin registers are updated on the transition edge so
  // each pin is already correct in the first cycle of the new phase.
  always_comb begin
    digit_d = digit_q;
    word_d  = word_q;
    bit_d   = bit_q;
    div_d   = div_q;
    dwell_d = dwell_q;
    shcp_d  = shcp_q;
    stcp_d  = stcp_q;
    oe_n_d  = oe_n_q;
    unique case (state_q)
      StLoad: begin
        word_d = {sel, seg};
        bit_d  = '0;
        div_d  = '0;
        shcp_d = 1'b0;
      end
      StShift: begin
        if (div_done) begin
          div_d = '0;
          if (!shcp_q) begin
            shcp_d = 1'b1;
          end else begin
            // Falling shcp: advance to the next bit; ds is word_q[15].
            shcp_d = 1'b0;
            word_d = {word_q[14:0], 1'b0};
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
              stcp_d = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StLatch: begin
        if (div_done) begin
          div_d   = '0;
          stcp_d  = 1'b0;
          oe_n_d  = 1'b0;
          dwell_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDwell: begin
        if (dwell_done) begin
          dwell_d = '0;
          digit_d = last_digit ? 3'd0 : digit_q + 3'd1;
          if (!en) begin
            oe_n_d = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      dwell_q <= '0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      digit_q <= digit_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      dwell_q <= dwell_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      oe_n_q  <= oe_n_d;
    end
  end

  // Outputs
  always_comb begin
    ds         = word_q[15];
    shcp       = shcp_q;
    stcp       = stcp_q;
    oe_n       = oe_n_q;
    busy       = (state_q != StIdle);
    frame_done = !reset && (state_q == StDwell) && dwell_done && last_digit;
  end

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Scoreboard bench for hc595_scan_ctrl: stimulus pushes the expected 16-bit
// words; the monitor rebuilds each word from ds on shcp rising edges and
// compares it when stcp rises.
module tb_hc595_scan_ctrl;
  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned N_DIGITS    = 6;
  localparam int unsigned SCAN_CYCLES = 100;
  localparam int          DIGIT_PER   = 1 + 33 * CLK_DIV + SCAN_CYCLES;  // 167
  localparam int          FRAME_PER   = N_DIGITS * DIGIT_PER;            // 1002

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  en;
  logic [4*N_DIGITS-1:0] disp_data;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank;
  logic                  ds, shcp, stcp, oe_n, busy, frame_done;

  hc595_scan_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .N_DIGITS   (N_DIGITS),
    .SCAN_CYCLES(SCAN_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .disp_data (disp_data),
    .dp        (dp),
    .blank     (blank),
    .ds        (ds),
    .shcp      (shcp),
    .stcp      (stcp),
    .oe_n      (oe_n),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          cyc = 0;
  bit          chk_period = 1'b0;

  // Monitor state
  logic        shcp_p = 1'b0;
  logic        stcp_p = 1'b0;
  logic [15:0] sh_word = '0;
  int          nbits = 0;
  int          stcp_len = 0;
  int          frames = 0;
  int          latches = 0;
  int          last_stcp = -1;
  int          last_frame = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      nbits      = 0;
      sh_word    = '0;
      stcp_len   = 0;
      shcp_p     = 1'b0;
      stcp_p     = 1'b0;
      last_stcp  = -1;
      last_frame = -1;
    end else begin
      if (shcp && !shcp_p) begin
        sh_word = {sh_word[14:0], ds};
        nbits++;
      end
      if (stcp) stcp_len++;
      if (stcp && !stcp_p) begin
        latches++;
        chk("bits_before_latch", nbits, 16);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_latch: word %h latched, none expected (cycle %0d)",
                   sh_word, cyc);
        end else begin
          chk("word", {16'h0, sh_word}, {16'h0, exp_q.pop_front()});
        end
        if (chk_period && last_stcp >= 0) chk("digit_period", cyc - last_stcp, DIGIT_PER);
        last_stcp = cyc;
        nbits     = 0;
      end
      if (!stcp && stcp_p) begin
        chk("stcp_high_cycles", stcp_len, CLK_DIV);
        chk("oe_n_after_latch", {31'h0, oe_n}, 0);
        stcp_len = 0;
      end
      if (frame_done) begin
        if (chk_period && last_frame >= 0) chk("frame_period", cyc - last_frame, FRAME_PER);
        last_frame = cyc;
        frames++;
      end
      shcp_p = shcp;
      stcp_p = stcp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) timeout("wait_idle");
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      tick();
      n++;
    end
    if (frames < target) timeout("wait_frames");
  endtask

  task automatic wait_latches(input int target, input int budget);
    int n = 0;
    while (latches < target && n < budget) begin
      tick();
      n++;
    end
    if (latches < target) timeout("wait_latches");
  endtask

  task automatic wait_bits(input int k, input int budget);
    int n = 0;
    while (nbits != k && n < budget) begin
      tick();
      n++;
    end
    if (nbits != k) timeout("wait_bits");
  endtask

  // digit0..5 for disp_data = 24'h012345 (nibbles 5,4,3,2,1,0)
  logic [15:0] scan_words[6] = '{16'h0192, 16'h0299, 16'h04B0, 16'h08A4, 16'h10F9, 16'h20C0};
  logic [15:0] dpbl_words[6] = '{16'h0112, 16'h0299, 16'h04B0, 16'h08A4, 16'h10F9, 16'h20FF};

  initial begin
    int bad;
    int f0;
    int l0;
    reset     = 1'b1;
    en        = 1'b0;
    disp_data = '0;
    dp        = '0;
    blank     = '0;

    // Reset and idle
    repeat (3) tick();
    chk("reset_ds", {31'h0, ds}, 0);
    chk("reset_shcp", {31'h0, shcp}, 0);
    chk("reset_stcp", {31'h0, stcp}, 0);
    chk("reset_oe_n", {31'h0, oe_n}, 1);
    chk("reset_busy", {31'h0, busy}, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ds || shcp || stcp || busy || !oe_n || frame_done) bad++;
    end
    chk("idle_activity", bad, 0);

    // Full scan, two frames; en stays high across the second frame_done so
    // digit 0 starts once more before the block goes idle.
    do_reset();
    disp_data = 24'h012345;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++) exp_q.push_back(scan_words[i]);
    exp_q.push_back(scan_words[0]);
    chk_period = 1'b1;
    f0 = frames;
    en = 1'b1;
    wait_frames(f0 + 2, 2 * FRAME_PER + 50);
    en = 1'b0;
    chk_period = 1'b0;
    wait_idle(DIGIT_PER + 10);
    chk("frames_seen", frames - f0, 2);
    chk("scan_oe_n_idle", {31'h0, oe_n}, 1);
    chk("scan_queue_drained", exp_q.size(), 0);

    // Decimal point on digit 0, blank on digit 5
    do_reset();
    dp    = 6'b000001;
    blank = 6'b100000;
    for (int i = 0; i < 6; i++) exp_q.push_back(dpbl_words[i]);
    exp_q.push_back(dpbl_words[0]);
    f0 = frames;
    en = 1'b1;
    wait_frames(f0 + 1, FRAME_PER + 50);
    en = 1'b0;
    wait_idle(DIGIT_PER + 10);
    chk("dpbl_queue_drained", exp_q.size(), 0);

    // Snapshot: change data mid-shift of digit 0, then drop en mid-shift of digit 1
    do_reset();
    dp        = '0;
    blank     = '0;
    disp_data = 24'h012345;
    exp_q.push_back(16'h0192);
    l0 = latches;
    en = 1'b1;
    wait_bits(5, 100);
    disp_data = 24'h0000A0;
    exp_q.push_back(16'h0288);
    wait_latches(l0 + 1, DIGIT_PER);
    wait_bits(3, DIGIT_PER);
    en = 1'b0;
    wait_idle(DIGIT_PER + 10);
    chk("disable_oe_n", {31'h0, oe_n}, 1);
    chk("disable_busy", {31'h0, busy}, 0);
    chk("disable_latches", latches - l0, 2);
    chk("disable_queue_drained", exp_q.size(), 0);

    // Resume at the retained digit (2), then drop en during its shift
    exp_q.push_back(16'h04C0);
    en = 1'b1;
    wait_bits(2, 100);
    en = 1'b0;
    wait_idle(DIGIT_PER + 10);
    chk("resume_queue_drained", exp_q.size(), 0);

    // Reset at bit 7 of digit 3: no latch, restart from digit 0
    l0 = latches;
    en = 1'b1;
    wait_bits(7, 100);
    reset = 1'b1;
    tick();
    chk("midreset_stcp", {31'h0, stcp}, 0);
    chk("midreset_oe_n", {31'h0, oe_n}, 1);
    reset = 1'b0;
    exp_q.push_back(16'h01C0);
    wait_latches(l0 + 1, DIGIT_PER + 10);
    en = 1'b0;
    wait_idle(DIGIT_PER + 10);
    chk("midreset_latches", latches - l0, 1);
    chk("midreset_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
